// File: rtl/adc_frame_sequencer.sv
// rtl/adc_frame_sequencer.sv - conversion pacing FSM and sample FIFO for the SPI ADC front end
//
// Purpose: drives ENA to the SPI master once every SAMPLE_PERIOD cycles,
// captures DATA when FIN is seen, and buffers words in a DEPTH-entry FIFO.
//
// Ports:
//   CLK, RST          - clock (shared with SPI master) and synchronous active-high reset
//   RUN               - enables periodic conversions (sampled in IDLE only)
//   ENA               - registered conversion request to the SPI master
//   FIN, DATA         - frame-complete level and received word from the SPI master
//   RD_EN, RD_DATA    - FIFO pop request and registered popped word
//   EMPTY, FULL, COUNT- FIFO status and occupancy
//   OVERFLOW          - sticky: a captured word was dropped on a full FIFO
//   TIMEOUT_ERR       - sticky: a conversion was aborted waiting for FIN
//   CLR_ERR           - clears both sticky flags (a same-cycle set wins)
module adc_frame_sequencer #(
  parameter int SAMPLE_PERIOD = 1024,
  parameter int TIMEOUT       = 64,
  parameter int GAP_CYCLES    = 4,
  parameter int DEPTH         = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RUN,
  output logic                     ENA,
  input  logic                     FIN,
  input  logic [15:0]              DATA,
  input  logic                     RD_EN,
  output logic [15:0]              RD_DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     TIMEOUT_ERR,
  input  logic                     CLR_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  // REQ loads SAMPLE_PERIOD-2: one cycle is spent in IDLE->REQ and one in
  // REQ->ENA, so successive ENA rising edges land exactly SAMPLE_PERIOD apart.
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 2);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            push_req;
  logic            timeout_hit;
  logic            pop;
  logic            push;
  logic            drop;

  // FIN takes priority over the timeout in the same WAIT cycle.
  assign push_req    = (state == WAIT) && FIN;
  assign timeout_hit = (state == WAIT) && !FIN && (to_cnt == TO_LAST);

  assign EMPTY = (COUNT == '0);
  assign FULL  = (COUNT == DEPTH_W);

  // A pop frees the slot a same-cycle push needs, so push at full is allowed then.
  assign pop  = RD_EN && !EMPTY;
  assign push = push_req && (!FULL || pop);
  assign drop = push_req && FULL && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ENA        <= 1'b0;
      period_cnt <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      // ENA follows the state one edge later, so it is high for REQ plus every WAIT cycle.
      ENA <= (state == REQ) || (state == WAIT);

      if (period_cnt != '0) begin
        period_cnt <= period_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (RUN && (period_cnt == '0)) begin
            state <= REQ;
          end
        end
        REQ: begin
          period_cnt <= PERIOD_LOAD;
          to_cnt     <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (FIN || (to_cnt == TO_LAST)) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          // Hold off until the master has dropped FIN so a stale FIN is never captured.
          if (gap_cnt == GAP_LAST) begin
            if (!FIN) begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      COUNT       <= '0;
      RD_DATA     <= '0;
      OVERFLOW    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        RD_DATA <= mem[rd_ptr];
      end
      if (push && !pop) begin
        COUNT <= COUNT + 1'b1;
      end else if (pop && !push) begin
        COUNT <= COUNT - 1'b1;
      end

      if (drop) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_ERR) begin
        OVERFLOW <= 1'b0;
      end

      if (timeout_hit) begin
        TIMEOUT_ERR <= 1'b1;
      end else if (CLR_ERR) begin
        TIMEOUT_ERR <= 1'b0;
      end
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DATA;
    end
  end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb/tb_adc_frame_sequencer.sv - scoreboard bench for adc_frame_sequencer
module tb_adc_frame_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RUN;
  logic        ENA;
  logic        FIN = 1'b0;
  logic [15:0] DATA = 16'h0000;
  logic        RD_EN = 1'b0;
  logic [15:0] RD_DATA;
  logic        EMPTY;
  logic        FULL;
  logic [3:0]  COUNT;
  logic        OVERFLOW;
  logic        TIMEOUT_ERR;
  logic        CLR_ERR;

  adc_frame_sequencer #(
    .SAMPLE_PERIOD(64),
    .TIMEOUT      (40),
    .GAP_CYCLES   (4),
    .DEPTH        (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RUN        (RUN),
    .ENA        (ENA),
    .FIN        (FIN),
    .DATA       (DATA),
    .RD_EN      (RD_EN),
    .RD_DATA    (RD_DATA),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .COUNT      (COUNT),
    .OVERFLOW   (OVERFLOW),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .CLR_ERR    (CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // master model / driver state
  logic [15:0] word_q[$];
  int          rises[$];
  int          ena_lens[$];
  logic        ena_d = 1'b0;
  logic        mact = 1'b0;
  int          mcyc = 0;
  int          cur_len = 0;
  int          fin_low = 0;
  logic        fin_first = 1'b0;
  logic        hold_fin = 1'b0;
  int          captures = 0;
  int          pops_req = 0;
  int          pops_done = 0;
  int          cap_pops_req = 0;
  int          cap_pops_done = 0;
  logic        rd_v;

  // scoreboard state
  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] model_rd = 16'h0000;
  logic        model_ovf = 1'b0;
  logic        m_set;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SPI master: FIN 19 cycles after ENA rises, drops FIN 2 cycles after ENA falls.
  always @(negedge CLK) begin
    fin_first = 1'b0;
    if (ENA && !ena_d) begin
      rises.push_back(cyc);
      mact    = 1'b1;
      mcyc    = 0;
      cur_len = 1;
    end else if (ENA) begin
      cur_len++;
      if (mact) begin
        mcyc++;
        if (mcyc == 19 && !hold_fin) begin
          FIN = 1'b1;
          if (word_q.size() > 0) DATA = word_q.pop_front();
          else DATA = 16'hDEAD;
          fin_first = 1'b1;
          captures++;
          mact    = 1'b0;
          fin_low = 0;
        end
      end
    end else begin
      mact = 1'b0;
      if (ena_d) ena_lens.push_back(cur_len);
      if (FIN) begin
        fin_low++;
        if (fin_low >= 2) FIN = 1'b0;
      end
    end
    ena_d = ENA;

    rd_v = 1'b0;
    if (pops_done < pops_req) begin
      rd_v = 1'b1;
      pops_done++;
    end
    if (fin_first && (cap_pops_req > cap_pops_done)) begin
      rd_v = 1'b1;
      cap_pops_done++;
    end
    RD_EN = rd_v;
  end

  // FIFO reference model: pushes expected read words into the scoreboard queue.
  always @(posedge CLK) begin
    if (RST) begin
      model_q.delete();
      exp_q.delete();
      model_rd  = 16'h0000;
      model_ovf = 1'b0;
    end else begin
      if (RD_EN && model_q.size() > 0) begin
        model_rd = model_q.pop_front();
        exp_q.push_back(model_rd);
      end
      m_set = 1'b0;
      if (fin_first) begin
        if (model_q.size() < 8) model_q.push_back(DATA);
        else m_set = 1'b1;
      end
      if (m_set) model_ovf = 1'b1;
      else if (CLR_ERR) model_ovf = 1'b0;
    end
  end

  // Monitor: compares DUT outputs against the model every cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("mon_count", 32'(COUNT), 32'(model_q.size()));
      check("mon_empty", 32'(EMPTY), 32'(model_q.size() == 0));
      check("mon_full", 32'(FULL), 32'(model_q.size() == 8));
      check("mon_overflow", 32'(OVERFLOW), 32'(model_ovf));
      if (exp_q.size() > 0) check("mon_rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
      else check("mon_rd_hold", 32'(RD_DATA), 32'(model_rd));
    end
  end

  task automatic wait_for(input int which, input int target, input int budget);
    int n;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      n = (which == 0) ? captures : (which == 1) ? rises.size() : ena_lens.size();
      if (n >= target) break;
      @(negedge CLK);
    end
    n = (which == 0) ? captures : (which == 1) ? rises.size() : ena_lens.size();
    check($sformatf("wait_%0d_reached", which), 32'(n >= target), 32'd1);
  endtask

  task automatic clear_errs();
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    @(negedge CLK);
  endtask

  int run_cyc;
  int base;
  int rb;
  int lb;

  initial begin
    RST = 1'b1;
    RUN = 1'b0;
    CLR_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ena", 32'(ENA), 32'd0);
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    check("rst_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    RST = 1'b0;
    mon_en = 1'b1;

    // basic capture
    word_q.push_back(16'hA5C3);
    word_q.push_back(16'h1234);
    word_q.push_back(16'hFFFF);
    @(negedge CLK);
    run_cyc = cyc;
    RUN = 1'b1;
    wait_for(0, 3, 300);
    RUN = 1'b0;
    repeat (10) @(negedge CLK);
    check("first_ena_latency", 32'(rises[0] - run_cyc), 32'd2);
    check("basic_period_1", 32'(rises[1] - rises[0]), 32'd64);
    check("basic_period_2", 32'(rises[2] - rises[1]), 32'd64);
    check("basic_count", 32'(COUNT), 32'd3);
    pops_req += 3;
    repeat (6) @(negedge CLK);
    check("basic_last_word", 32'(RD_DATA), 32'hFFFF);
    check("basic_empty", 32'(EMPTY), 32'd1);
    check("basic_overflow", 32'(OVERFLOW), 32'd0);
    check("basic_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    pops_req += 1;
    repeat (3) @(negedge CLK);
    check("empty_pop_hold", 32'(RD_DATA), 32'hFFFF);
    check("empty_pop_count", 32'(COUNT), 32'd0);

    // overflow
    for (int i = 1; i <= 10; i++) word_q.push_back(16'(16'h1000 + i));
    base = captures;
    RUN = 1'b1;
    wait_for(0, base + 8, 700);
    repeat (3) @(negedge CLK);
    check("ovf_full_at_8", 32'(FULL), 32'd1);
    check("ovf_not_yet", 32'(OVERFLOW), 32'd0);
    wait_for(0, base + 9, 100);
    repeat (3) @(negedge CLK);
    check("ovf_set_at_9", 32'(OVERFLOW), 32'd1);
    wait_for(0, base + 10, 100);
    RUN = 1'b0;
    repeat (10) @(negedge CLK);
    pops_req += 8;
    repeat (12) @(negedge CLK);
    check("ovf_last_word", 32'(RD_DATA), 32'h1008);
    check("ovf_empty", 32'(EMPTY), 32'd1);
    clear_errs();
    check("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // timeout
    repeat (70) @(negedge CLK);
    hold_fin = 1'b1;
    rb = rises.size();
    lb = ena_lens.size();
    RUN = 1'b1;
    wait_for(2, lb + 1, 200);
    check("to_ena_len", 32'(ena_lens[lb]), 32'd41);
    check("to_err_set", 32'(TIMEOUT_ERR), 32'd1);
    check("to_nothing_pushed", 32'(COUNT), 32'd0);
    wait_for(1, rb + 2, 200);
    RUN = 1'b0;
    check("to_period", 32'(rises[rb + 1] - rises[rb]), 32'd64);
    wait_for(2, lb + 2, 200);
    repeat (10) @(negedge CLK);
    hold_fin = 1'b0;
    clear_errs();
    check("to_err_cleared", 32'(TIMEOUT_ERR), 32'd0);

    // simultaneous push and pop at full
    repeat (70) @(negedge CLK);
    for (int i = 1; i <= 9; i++) word_q.push_back(16'(16'h2000 + i));
    base = captures;
    RUN = 1'b1;
    wait_for(0, base + 8, 700);
    cap_pops_req = cap_pops_done + 1;
    wait_for(0, base + 9, 100);
    RUN = 1'b0;
    repeat (3) @(negedge CLK);
    check("pp_count_8", 32'(COUNT), 32'd8);
    check("pp_no_overflow", 32'(OVERFLOW), 32'd0);
    check("pp_oldest_word", 32'(RD_DATA), 32'h2001);
    repeat (60) @(negedge CLK);
    pops_req += 8;
    repeat (12) @(negedge CLK);
    check("pp_last_word", 32'(RD_DATA), 32'h2009);
    check("pp_empty", 32'(EMPTY), 32'd1);

    // reset mid-conversion
    repeat (70) @(negedge CLK);
    hold_fin = 1'b1;
    lb = ena_lens.size();
    RUN = 1'b1;
    wait_for(2, lb + 1, 200);
    hold_fin = 1'b0;
    word_q.push_back(16'h3001);
    word_q.push_back(16'h4001);
    base = captures;
    wait_for(0, base + 1, 200);
    rb = rises.size();
    wait_for(1, rb + 1, 200);
    repeat (5) @(negedge CLK);
    check("rst_pre_count", 32'(COUNT), 32'd1);
    check("rst_pre_timeout", 32'(TIMEOUT_ERR), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_ena", 32'(ENA), 32'd0);
    check("rst_mid_count", 32'(COUNT), 32'd0);
    check("rst_mid_timeout", 32'(TIMEOUT_ERR), 32'd0);
    check("rst_mid_rd_data", 32'(RD_DATA), 32'd0);
    repeat (2) @(negedge CLK);
    rb = rises.size();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_release_ena", 32'(ENA), 32'd1);

    // RUN dropped during WAIT
    wait_for(1, rb + 1, 5);
    repeat (5) @(negedge CLK);
    base = captures;
    RUN = 1'b0;
    wait_for(0, base + 1, 100);
    rb = rises.size();
    repeat (200) @(negedge CLK);
    check("run_off_no_ena", 32'(rises.size()), 32'(rb));
    check("run_off_count", 32'(COUNT), 32'd1);
    pops_req += 1;
    repeat (3) @(negedge CLK);
    check("run_off_word", 32'(RD_DATA), 32'h4001);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
